soc_it_slave_responder: RTL

- Target-side (responder) end of the SoC-IT slave port: accepts address/request phases from a SoC-IT master and returns address_ack, wrack, rdack and read data.
- Backed by an internal byte-enabled 128-bit memory window.
- Used as a bench/system memory target and as the template for register-mapped slaves.
- Supports single-beat and burst reads and writes, with programmable ack and read latency.

---
 rtl/soc_it_pkg.sv | 25 ++
 rtl/soc_it_resp_mem.sv | 34 +++
 rtl/soc_it_slave_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/soc_it_pkg.sv
// Shared widths and enumerations for the SoC-IT slave responder and its memory.
package soc_it_pkg;

    localparam int SOC_IT_BEAT_W = 128;
    localparam int SOC_IT_BE_W   = 16;
    localparam int SOC_IT_ADDR_W = 64;
    localparam int SOC_IT_ID_W   = 4;
    localparam int SOC_IT_LEN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DLY,
        ST_ACK,
        ST_WR,
        ST_RD_WAIT,
        ST_RD
    } soc_it_resp_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_WR,
        REQ_RD
    } soc_it_req_t;

endpackage

// File: rtl/soc_it_resp_mem.sv
// DEPTH x 128-bit RAM with byte-enabled write and a registered (1-cycle) read port.
module soc_it_resp_mem
    import soc_it_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [SOC_IT_BE_W-1:0]   be_i,
    input  logic [SOC_IT_BEAT_W-1:0] wdata_i,
    input  logic [AW-1:0]            raddr_i,
    output logic [SOC_IT_BEAT_W-1:0] rdata_o
);

    logic [SOC_IT_BEAT_W-1:0] mem_q [DEPTH];
    logic [SOC_IT_BEAT_W-1:0] rdata_q;

    // No reset here: contents must survive a reset of the responder.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < SOC_IT_BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/soc_it_slave_responder.sv
// SoC-IT slave port responder: accepts requests, acks them and serves
// single/burst reads and writes from an internal byte-enabled memory window.
module soc_it_slave_responder
    import soc_it_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          DEPTH      = 256,
    parameter int          ACK_DELAY  = 0,
    parameter int          RD_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SOC_IT_ADDR_W-1:0] slave_address,
    input  logic [SOC_IT_ID_W-1:0]   slave_transaction_id,
    input  logic                     slave_address_valid,
    output logic                     slave_address_ack,
    input  logic [SOC_IT_LEN_W-1:0]  slave_wrreq,
    output logic                     slave_wrack,
    input  logic [SOC_IT_BE_W-1:0]   slave_be,
    input  logic [SOC_IT_BEAT_W-1:0] slave_datain,
    input  logic [SOC_IT_LEN_W-1:0]  slave_rdreq,
    output logic                     slave_rdack,
    output logic [SOC_IT_BEAT_W-1:0] slave_dataout,
    output logic [SOC_IT_ID_W-1:0]   last_txn_id,
    output logic                     busy,
    output logic                     err,
    output logic [15:0]              err_count
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [63:0] WINDOW_BYTES = 64'(DEPTH) << 4;
    localparam logic [3:0]  DLY_INIT     = 4'(ACK_DELAY > 0 ? ACK_DELAY - 1 : 0);
    localparam logic [15:0] WAIT_INIT    = 16'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);

    soc_it_resp_state_t       state_q;
    soc_it_req_t              type_q;
    logic [SOC_IT_LEN_W-1:0]  beats_q;
    logic [AW-1:0]            idx_q;
    logic [SOC_IT_ID_W-1:0]   id_q;
    logic                     inRange_q;
    logic                     errPend_q;
    logic [3:0]               dly_q;
    logic [15:0]              wait_q;
    logic                     ack_q;
    logic                     wrack_q;
    logic                     rdack_q;
    logic                     err_q;
    logic [15:0]              errCount_q;
    logic [SOC_IT_ID_W-1:0]   lastId_q;

    logic [63:0]              reqOffset;
    logic [AW-1:0]            reqIdx;
    logic                     reqInRange;
    logic                     reqErr;
    soc_it_req_t              reqType;
    logic [SOC_IT_LEN_W-1:0]  reqLen;
    logic                     enterAck;
    logic [SOC_IT_ID_W-1:0]   ackId;
    logic                     ackErr;
    logic                     memWe;
    logic [SOC_IT_BEAT_W-1:0] memRdata;

    assign reqOffset  = slave_address - BASE_ADDR;
    assign reqIdx     = AW'(reqOffset >> 4);
    assign reqInRange = (slave_address >= BASE_ADDR) && (reqOffset < WINDOW_BYTES);

    // A request carrying both counts is served as a write; one with neither is acked only.
    always_comb begin
        reqType = REQ_NONE;
        reqLen  = '0;
        if (slave_wrreq != '0) begin
            reqType = REQ_WR;
            reqLen  = slave_wrreq;
        end else if (slave_rdreq != '0) begin
            reqType = REQ_RD;
            reqLen  = slave_rdreq;
        end
    end

    assign reqErr = ((slave_wrreq != '0) && (slave_rdreq != '0)) ||
                    ((slave_wrreq == '0) && (slave_rdreq == '0)) || !reqInRange;

    assign enterAck = ((state_q == ST_IDLE) && slave_address_valid && (ACK_DELAY == 0)) ||
                      ((state_q == ST_DLY) && (dly_q == 4'd0));
    assign ackId    = (state_q == ST_IDLE) ? slave_transaction_id : id_q;
    assign ackErr   = (state_q == ST_IDLE) ? reqErr : errPend_q;

    // Setting rdack for the next cycle also advances idx_q; the RAM captures
    // mem[idx_q] on that same edge, so read data lines up with rdack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            type_q     <= REQ_NONE;
            beats_q    <= '0;
            idx_q      <= '0;
            id_q       <= '0;
            inRange_q  <= 1'b0;
            errPend_q  <= 1'b0;
            dly_q      <= '0;
            wait_q     <= '0;
            ack_q      <= 1'b0;
            wrack_q    <= 1'b0;
            rdack_q    <= 1'b0;
            err_q      <= 1'b0;
            errCount_q <= '0;
            lastId_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (slave_address_valid) begin
                        idx_q     <= reqIdx;
                        id_q      <= slave_transaction_id;
                        type_q    <= reqType;
                        beats_q   <= reqLen;
                        inRange_q <= reqInRange;
                        errPend_q <= reqErr;
                        if (ACK_DELAY > 0) begin
                            state_q <= ST_DLY;
                            dly_q   <= DLY_INIT;
                        end else begin
                            state_q <= ST_ACK;
                        end
                    end
                end
                ST_DLY: begin
                    if (dly_q == 4'd0) state_q <= ST_ACK;
                    else               dly_q   <= dly_q - 4'd1;
                end
                ST_ACK: begin
                    case (type_q)
                        REQ_WR: begin
                            state_q <= ST_WR;
                            wrack_q <= 1'b1;
                        end
                        REQ_RD: begin
                            if (RD_LATENCY <= 1) begin
                                state_q <= ST_RD;
                                rdack_q <= 1'b1;
                                idx_q   <= idx_q + AW'(1);
                                beats_q <= beats_q - 4'd1;
                            end else begin
                                state_q <= ST_RD_WAIT;
                                wait_q  <= WAIT_INIT;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
                ST_WR: begin
                    if (wrack_q) begin
                        wrack_q <= 1'b0;
                        idx_q   <= idx_q + AW'(1);
                        beats_q <= beats_q - 4'd1;
                        if (beats_q == 4'd1) state_q <= ST_IDLE;
                    end else begin
                        wrack_q <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_q == 16'd0) begin
                        state_q <= ST_RD;
                        rdack_q <= 1'b1;
                        idx_q   <= idx_q + AW'(1);
                        beats_q <= beats_q - 4'd1;
                    end else begin
                        wait_q <= wait_q - 16'd1;
                    end
                end
                ST_RD: begin
                    if (beats_q != 4'd0) begin
                        rdack_q <= 1'b1;
                        idx_q   <= idx_q + AW'(1);
                        beats_q <= beats_q - 4'd1;
                    end else begin
                        rdack_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (enterAck) begin
                ack_q    <= 1'b1;
                lastId_q <= ackId;
                if (ackErr) begin
                    err_q <= 1'b1;
                    if (errCount_q != 16'hFFFF) errCount_q <= errCount_q + 16'd1;
                end
            end
        end
    end

    assign memWe = (state_q == ST_WR) && wrack_q && inRange_q;

    soc_it_resp_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (memWe),
        .waddr_i (idx_q),
        .be_i    (slave_be),
        .wdata_i (slave_datain),
        .raddr_i (idx_q),
        .rdata_o (memRdata)
    );

    assign slave_address_ack = ack_q;
    assign slave_wrack       = wrack_q;
    assign slave_rdack       = rdack_q;
    assign slave_dataout     = (rdack_q && inRange_q) ? memRdata : '0;
    assign last_txn_id       = lastId_q;
    assign busy              = (state_q != ST_IDLE);
    assign err               = err_q;
    assign err_count         = errCount_q;

endmodule
